// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and serialiser states.
package usr_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        LOAD = 3'b001,
        SHL  = 3'b010,
        SHR  = 3'b011,
        ROTL = 3'b100,
        ROTR = 3'b101,
        ASR  = 3'b110,
        SER  = 3'b111
    } usr_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_e;

endpackage

// File: rtl/usr_ser_ctrl.sv
// Serialiser sequencer: owns state, bit counter, busy and done; tells the datapath
// when it must shift left regardless of the requested mode.
module usr_ser_ctrl
    import usr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic clk,
    input  logic n_reset,
    input  logic n_clr,
    input  logic en,
    input  logic start,
    output logic shift,
    output logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(N);

    usr_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;

    always_ff @(posedge clk) begin
        if (!n_reset || !n_clr) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            // done is a single-cycle pulse, dropped even when en is low
            done_reg <= 1'b0;
            if (state_reg == SHIFT) begin
                if (en) begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
            end else if (en && start) begin
                state_reg <= SHIFT;
                cnt_reg   <= CNT_W'(N - 1);
                busy_reg  <= 1'b1;
            end
        end
    end

    assign shift = (state_reg == SHIFT);
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal N-bit register: hold, load, shifts, rotates and an MSB-first serialiser.
// Define USR_PARITY_EN to add a registered even-parity output.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         n_clr,
    input  logic         en,
    input  logic [2:0]   mode,
    input  logic [N-1:0] D,
    input  logic         sl_in,
    input  logic         sr_in,
    output logic [N-1:0] Q,
    output logic [N-1:0] Q_bar,
    output logic         ser_out,
    output logic         busy,
`ifdef USR_PARITY_EN
    output logic         parity,
`endif
    output logic         done
);

    logic [N-1:0] q_reg;
    logic [N-1:0] q_next;
    logic         shift;
    usr_mode_e    mode_sel;

    assign mode_sel = usr_mode_e'(mode);

    usr_ser_ctrl #(.N(N)) u_ser_ctrl (
        .clk     (clk),
        .n_reset (n_reset),
        .n_clr   (n_clr),
        .en      (en),
        .start   (mode_sel == SER),
        .shift   (shift),
        .busy    (busy),
        .done    (done)
    );

    // A running serialise overrides the mode decode
    always_comb begin
        q_next = q_reg;
        if (en) begin
            if (shift) begin
                q_next = {q_reg[N-2:0], sl_in};
            end else begin
                case (mode_sel)
                    HOLD:    q_next = q_reg;
                    LOAD:    q_next = D;
                    SHL:     q_next = {q_reg[N-2:0], sl_in};
                    SHR:     q_next = {sr_in, q_reg[N-1:1]};
                    ROTL:    q_next = {q_reg[N-2:0], q_reg[N-1]};
                    ROTR:    q_next = {q_reg[0], q_reg[N-1:1]};
                    ASR:     q_next = {q_reg[N-1], q_reg[N-1:1]};
                    SER:     q_next = D;
                    default: q_next = q_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset || !n_clr) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

`ifdef USR_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk) begin
        if (!n_reset || !n_clr) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= ^q_next;
        end
    end

    assign parity = parity_reg;
`endif

    assign Q       = q_reg;
    assign Q_bar   = ~q_reg;
    assign ser_out = q_reg[N-1];

endmodule
